uart_rx32: RTL and testbench

//  Serial receiver paired with the 32-bit UART transmitter: recovers 32-bit words from the Rxd line.

---
 rtl/uart_rx32.sv | 150 +++++++++++++++
 tb/tb_uart_rx32.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx32.sv
// uart_rx32: oversampled UART receiver for 32-bit frames.
// Frame: start bit (0), DATA_BITS data bits LSB first, stop bit (1).
// The start edge is detected on any PCLK. Every later decision is made on
// tick pulses, using the synchronised line value.
module uart_rx32 #(
    parameter int DATA_BITS  = 32,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 tick,
    input  logic                 Rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 RxD_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    rx_state_t              r_state, w_state_nx;
    logic [1:0]             r_sync;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]       r_idx, w_idx_nx;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nx;
    logic [DATA_BITS-1:0]   r_rx_data, w_rx_data_nx;
    logic                   r_done, w_done_nx;
    logic                   r_ferr, w_ferr_nx;
    logic                   w_rxs;

    // The second synchroniser flop is the only view of the line the FSM uses.
    assign w_rxs = r_sync[1];

    // Two-flop synchroniser. It resets to the idle (high) line level.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], Rxd};
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_shift   <= w_shift_nx;
            r_rx_data <= w_rx_data_nx;
            r_done    <= w_done_nx;
            r_ferr    <= w_ferr_nx;
        end
    end

    // Next-state logic. Outside IDLE, everything advances only on tick.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_idx_nx     = r_idx;
        w_shift_nx   = r_shift;
        w_rx_data_nx = r_rx_data;
        w_done_nx    = 1'b0;
        w_ferr_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                w_idx_nx = '0;
                if (!w_rxs) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (r_cnt == HALF_M1) begin
                        // At mid start bit: a high line here means the edge was a glitch.
                        if (!w_rxs) begin
                            w_cnt_nx   = '0;
                            w_state_nx = S_DATA;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (r_cnt == FULL_M1) begin
                        w_shift_nx = {w_rxs, r_shift[DATA_BITS-1:1]};
                        w_cnt_nx   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nx   = '0;
                            w_state_nx = S_STOP;
                        end else begin
                            w_idx_nx = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (r_cnt == FULL_M1) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                        if (w_rxs) begin
                            w_rx_data_nx = r_shift;
                            w_done_nx    = 1'b1;
                        end else begin
                            w_ferr_nx = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign RxD_done  = r_done;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx32.sv
// Bench for uart_rx32. A serial line driver feeds frames into the receiver,
// and each frame queues the outcome it should produce. A monitor pops one
// entry for every done or frame_err pulse and compares it.
module tb_uart_rx32;

    logic        PCLK;
    logic        PRESETn;
    logic        tick;
    logic        Rxd;
    logic [31:0] rx_data;
    logic        RxD_done;
    logic        frame_err;
    logic        rx_busy;

    // Queue entry: bit 32 = frame error expected; bits 31:0 = rx_data expected at the pulse.
    logic [32:0] exp_q[$];
    logic [31:0] last_good;
    int          n_cmp;
    int          n_err;
    int          tick_div;
    int          tcnt;

    uart_rx32 #(.DATA_BITS(32), .OVERSAMPLE(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .tick      (tick),
        .Rxd       (Rxd),
        .rx_data   (rx_data),
        .RxD_done  (RxD_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    // ---------------- clock / tick / reset ----------------
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        tick = 1'b0;
        tcnt = 0;
        forever begin
            @(negedge PCLK);
            if (tcnt >= tick_div - 1) begin
                tick = 1'b1;
                tcnt = 0;
            end else begin
                tick = 1'b0;
                tcnt = tcnt + 1;
            end
        end
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v, input int n_pclk);
        Rxd = v;
        repeat (n_pclk) @(negedge PCLK);
    endtask

    // Sends one frame. A bad stop bit is held low for 3/4 of a bit and then
    // released, so the receiver re-arms and rejects the tail as a glitch.
    // abort_bit >= 0 stops mid-way through that data bit and queues nothing.
    task automatic send_frame(input logic [31:0] data, input logic stop_ok,
                              input int bit_pclk, input int abort_bit);
        if (abort_bit < 0) begin
            if (stop_ok) begin
                exp_q.push_back({1'b0, data});
                last_good = data;
            end else begin
                exp_q.push_back({1'b1, last_good});
            end
        end
        drive_bit(1'b0, bit_pclk);
        for (int i = 0; i < 32; i++) begin
            if (i == abort_bit) begin
                drive_bit(data[i], bit_pclk / 2);
                return;
            end
            drive_bit(data[i], bit_pclk);
        end
        if (stop_ok) begin
            drive_bit(1'b1, bit_pclk);
        end else begin
            drive_bit(1'b0, (bit_pclk * 3) / 4);
            drive_bit(1'b1, bit_pclk - (bit_pclk * 3) / 4);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        prev_pulse;
        logic [32:0] e;
        prev_pulse = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (prev_pulse) begin
                    chk("pulse_width", {31'b0, RxD_done, frame_err}, 33'b0);
                end
                if (RxD_done && frame_err) begin
                    chk("done_and_err", 33'd1, 33'd0);
                end
                if (RxD_done || frame_err) begin
                    if (exp_q.size() == 0) begin
                        n_cmp = n_cmp + 1;
                        n_err = n_err + 1;
                        $display("FAIL unexpected_pulse: done=%0b err=%0b data=%h expected no pulse",
                                 RxD_done, frame_err, rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_kind", {32'b0, frame_err}, {32'b0, e[32]});
                        chk("rx_data", {1'b0, rx_data}, {1'b0, e[31:0]});
                    end
                end
                prev_pulse = RxD_done || frame_err;
            end else begin
                prev_pulse = 1'b0;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        logic        ok;
        int          gap;
        n_cmp     = 0;
        n_err     = 0;
        last_good = 32'h0;
        tick_div  = 16;
        Rxd       = 1'b1;
        PRESETn   = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("reset_rx_data", {1'b0, rx_data}, 33'h0);
        chk("reset_pulses", {30'b0, RxD_done, frame_err, rx_busy}, 33'h0);
        PRESETn = 1'b1;
        repeat (40) @(negedge PCLK);
        chk("idle_busy", {32'b0, rx_busy}, 33'h0);

        // Basic frame at 16 PCLK per tick.
        send_frame(32'hA5A5_0F0F, 1'b1, 256, -1);
        drive_bit(1'b1, 256);

        // Short low pulse: 4 ticks, must be rejected at mid start bit.
        drive_bit(1'b0, 32);
        chk("glitch_busy_high", {32'b0, rx_busy}, 33'h1);
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 16 * 12);
        chk("glitch_busy_low", {32'b0, rx_busy}, 33'h0);

        // Bad stop bit: error pulse, rx_data stays at the previous word.
        send_frame(32'h1234_5678, 1'b0, 256, -1);
        drive_bit(1'b1, 512);

        // Back-to-back frames with no idle gap.
        tick_div = 4;
        drive_bit(1'b1, 64);
        send_frame(32'hFFFF_FFFF, 1'b1, 64, -1);
        send_frame(32'h0000_0001, 1'b1, 64, -1);
        drive_bit(1'b1, 128);

        // Reset in the middle of data bit 10, then a clean frame.
        send_frame(32'hDEAD_BEEF, 1'b1, 64, 10);
        Rxd     = 1'b1;
        PRESETn = 1'b0;
        #1;
        chk("midreset_rx_data", {1'b0, rx_data}, 33'h0);
        chk("midreset_outs", {30'b0, RxD_done, frame_err, rx_busy}, 33'h0);
        last_good = 32'h0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        drive_bit(1'b1, 128);
        send_frame(32'hDEAD_BEEF, 1'b1, 64, -1);
        drive_bit(1'b1, 128);

        // Random frames at 2 PCLK per tick, some with bad stop bits.
        tick_div = 2;
        drive_bit(1'b1, 64);
        for (int k = 0; k < 12; k++) begin
            d  = $urandom;
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok, 32, -1);
            gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
            drive_bit(1'b1, gap * 32 + 2);
        end
        drive_bit(1'b1, 64);

        // Sender slightly slow then slightly fast at 32 PCLK per tick.
        tick_div = 32;
        drive_bit(1'b1, 64);
        send_frame(32'h5555_AAAA, 1'b1, 513, -1);
        drive_bit(1'b1, 512);
        send_frame(32'h5555_AAAA, 1'b1, 511, -1);
        drive_bit(1'b1, 512);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(negedge PCLK);
        chk("queue_empty", 33'(exp_q.size()), 33'h0);
        chk("final_busy", {32'b0, rx_busy}, 33'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
